// File: rtl/gcn_pkg.sv
// Shared types and arithmetic helpers for the GCN aggregation stage.
package gcn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SELF,
    ST_EDGE_A,
    ST_EDGE_B,
    ST_ARGMAX,
    ST_DONE
  } state_e;

  localparam int unsigned SAT_W  = 64;
  localparam int unsigned SAT_SW = SAT_W + 1;

  // Unsigned add clamped to 2^width-1; callers keep width below SAT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      width);
    logic [SAT_SW-1:0] sum;
    logic [SAT_SW-1:0] lim;
    sum = SAT_SW'(a) + SAT_SW'(b);
    lim = (SAT_SW'(1) << width) - SAT_SW'(1);
    return (sum > lim) ? SAT_W'(lim) : SAT_W'(sum);
  endfunction

endpackage

// File: rtl/gcn_coo_aggregator_if.sv
// Product-row, COO and result bus between the aggregator and its memories/host.
interface gcn_coo_aggregator_if #(
  parameter int unsigned NUM_OF_NODES   = 6,
  parameter int unsigned NUM_OF_CLASSES = 3,
  parameter int unsigned NUM_OF_EDGES   = 6,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned NODE_BW        = $clog2(NUM_OF_NODES),
  parameter int unsigned CLASS_BW       = $clog2(NUM_OF_CLASSES),
  parameter int unsigned EDGE_BW        = $clog2(NUM_OF_EDGES)
);

  logic                                           start;
  logic [NODE_BW-1:0]                             fm_wm_row_address;
  logic [NUM_OF_CLASSES-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_row_in;
  logic [EDGE_BW-1:0]                             coo_address;
  logic [2*NODE_BW-1:0]                           coo_in;
  logic                                           done;
  logic                                           coo_error;
  logic [NUM_OF_NODES-1:0][CLASS_BW-1:0]          max_addi_answer;

  modport master (
    input  start, fm_wm_row_in, coo_in,
    output fm_wm_row_address, coo_address, done, coo_error, max_addi_answer
  );

  modport slave (
    output start, fm_wm_row_in, coo_in,
    input  fm_wm_row_address, coo_address, done, coo_error, max_addi_answer
  );

endinterface

// File: rtl/gcn_argmax.sv
// Combinational argmax over one accumulator row; ties keep the lowest class index.
module gcn_argmax #(
  parameter int unsigned NUM_OF_CLASSES = 3,
  parameter int unsigned AGG_WIDTH      = 20,
  parameter int unsigned CLASS_BW       = $clog2(NUM_OF_CLASSES)
) (
  input  logic [NUM_OF_CLASSES-1:0][AGG_WIDTH-1:0] row,
  output logic [CLASS_BW-1:0]                      idx_c
);

  logic [AGG_WIDTH-1:0] best;

  always_comb begin
    idx_c = '0;
    best  = row[0];
    for (int unsigned c = 1; c < NUM_OF_CLASSES; c++) begin
      if (row[c] > best) begin
        best  = row[c];
        idx_c = CLASS_BW'(c);
      end
    end
  end

endmodule

// File: rtl/gcn_coo_aggregator.sv
// Walks the COO edge list summing neighbour product rows per node, then
// writes the per-node argmax class.
module gcn_coo_aggregator
  import gcn_pkg::*;
#(
  parameter int unsigned NUM_OF_NODES   = 6,
  parameter int unsigned NUM_OF_CLASSES = 3,
  parameter int unsigned NUM_OF_EDGES   = 6,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned AGG_WIDTH      = 20,
  parameter int unsigned SELF_LOOP      = 1,
  parameter int unsigned UNDIRECTED     = 1,
  parameter int unsigned NODE_BW        = $clog2(NUM_OF_NODES),
  parameter int unsigned CLASS_BW       = $clog2(NUM_OF_CLASSES),
  parameter int unsigned EDGE_BW        = $clog2(NUM_OF_EDGES)
) (
  input logic                  clk,
  input logic                  reset,
  gcn_coo_aggregator_if.master bus
);

  typedef logic [NUM_OF_CLASSES-1:0][AGG_WIDTH-1:0] agg_row_t;

  state_e                                state_q, state_d;
  logic [NODE_BW-1:0]                    node_q;
  logic [NODE_BW-1:0]                    row_addr_q;
  logic [EDGE_BW-1:0]                    edge_q;
  agg_row_t                              agg_q [NUM_OF_NODES];
  logic [NUM_OF_NODES-1:0][CLASS_BW-1:0] ans_q;
  logic                                  done_q;
  logic                                  coo_error_q;

  logic [NODE_BW-1:0]  src_c, dst_c, acc_node_c;
  logic                edge_ok_c, node_last_c, edge_last_c, acc_en_c;
  agg_row_t            argmax_row_c;
  logic [CLASS_BW-1:0] argmax_idx_c;

  assign src_c       = bus.coo_in[2*NODE_BW-1:NODE_BW];
  assign dst_c       = bus.coo_in[NODE_BW-1:0];
  assign edge_ok_c   = (32'(src_c) < NUM_OF_NODES) && (32'(dst_c) < NUM_OF_NODES);
  assign node_last_c = (node_q == NODE_BW'(NUM_OF_NODES - 1));
  assign edge_last_c = (edge_q == EDGE_BW'(NUM_OF_EDGES - 1));

  // dst is only known once coo_address is out, so EDGE_A forwards it from coo_in
  assign bus.fm_wm_row_address = (state_q == ST_EDGE_A) ? dst_c : row_addr_q;
  assign bus.coo_address       = edge_q;
  assign bus.done              = done_q;
  assign bus.coo_error         = coo_error_q;
  assign bus.max_addi_answer   = ans_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and accumulator target selection
  always_comb begin
    state_d    = state_q;
    acc_en_c   = 1'b0;
    acc_node_c = node_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = (SELF_LOOP != 0) ? ST_SELF : ST_EDGE_A;
      ST_SELF: begin
        acc_en_c = 1'b1;
        if (node_last_c) state_d = ST_EDGE_A;
      end
      ST_EDGE_A: begin
        acc_en_c   = edge_ok_c;
        acc_node_c = src_c;
        if (UNDIRECTED != 0) state_d = ST_EDGE_B;
        else if (edge_last_c) state_d = ST_ARGMAX;
      end
      ST_EDGE_B: begin
        acc_en_c   = edge_ok_c;
        acc_node_c = dst_c;
        state_d    = edge_last_c ? ST_ARGMAX : ST_EDGE_A;
      end
      ST_ARGMAX: if (node_last_c) state_d = ST_DONE;
      ST_DONE:   if (!bus.start) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counters, addresses, flags and answers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      node_q      <= '0;
      row_addr_q  <= '0;
      edge_q      <= '0;
      ans_q       <= '0;
      done_q      <= 1'b0;
      coo_error_q <= 1'b0;
    end else begin
      done_q <= (state_d == ST_DONE);
      case (state_q)
        ST_CLEAR: begin
          node_q      <= '0;
          row_addr_q  <= '0;
          edge_q      <= '0;
          coo_error_q <= 1'b0;
        end
        ST_SELF: begin
          node_q     <= node_last_c ? '0 : node_q + NODE_BW'(1);
          row_addr_q <= node_last_c ? '0 : node_q + NODE_BW'(1);
        end
        ST_EDGE_A: begin
          if (!edge_ok_c) coo_error_q <= 1'b1;
          if (UNDIRECTED != 0) row_addr_q <= src_c;
          else edge_q <= edge_last_c ? '0 : edge_q + EDGE_BW'(1);
        end
        ST_EDGE_B: begin
          if (!edge_ok_c) coo_error_q <= 1'b1;
          edge_q <= edge_last_c ? '0 : edge_q + EDGE_BW'(1);
        end
        ST_ARGMAX: begin
          ans_q[node_q] <= argmax_idx_c;
          node_q        <= node_last_c ? '0 : node_q + NODE_BW'(1);
        end
        default: ;
      endcase
    end
  end

  // Saturating accumulators, one row added to one node per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned n = 0; n < NUM_OF_NODES; n++) agg_q[n] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int unsigned n = 0; n < NUM_OF_NODES; n++) agg_q[n] <= '0;
    end else if (acc_en_c) begin
      for (int unsigned n = 0; n < NUM_OF_NODES; n++) begin
        if (acc_node_c == NODE_BW'(n)) begin
          for (int unsigned c = 0; c < NUM_OF_CLASSES; c++) begin
            agg_q[n][c] <= AGG_WIDTH'(sat_add(SAT_W'(agg_q[n][c]),
                                              SAT_W'(DOT_PROD_WIDTH'(bus.fm_wm_row_in[c])),
                                              AGG_WIDTH));
          end
        end
      end
    end
  end

  always_comb begin
    argmax_row_c = '0;
    for (int unsigned n = 0; n < NUM_OF_NODES; n++) begin
      if (node_q == NODE_BW'(n)) argmax_row_c = agg_q[n];
    end
  end

  gcn_argmax #(
    .NUM_OF_CLASSES (NUM_OF_CLASSES),
    .AGG_WIDTH      (AGG_WIDTH),
    .CLASS_BW       (CLASS_BW)
  ) u_argmax (
    .row   (argmax_row_c),
    .idx_c (argmax_idx_c)
  );

endmodule

// File: tb/tb_gcn_coo_aggregator.sv
// Directed bench for gcn_coo_aggregator: default instance plus a saturating
// 16-bit directed-edge instance, checked against a scoreboard of expected answers.
module tb_gcn_coo_aggregator;

  localparam int unsigned N  = 6;
  localparam int unsigned C  = 3;
  localparam int unsigned E  = 6;
  localparam int unsigned DW = 16;

  typedef logic [C-1:0][DW-1:0] row_t;
  typedef logic [5:0]           coo_t;
  typedef logic [N-1:0][1:0]    ans_t;
  typedef struct packed { ans_t ans; logic err; } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  row_t rows_a [N];
  coo_t coo_a  [E];
  row_t rows_s [N];
  coo_t coo_s  [E];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  gcn_coo_aggregator_if #(.NUM_OF_NODES(N), .NUM_OF_CLASSES(C), .NUM_OF_EDGES(E),
                          .DOT_PROD_WIDTH(DW)) bus_a ();
  gcn_coo_aggregator_if #(.NUM_OF_NODES(N), .NUM_OF_CLASSES(C), .NUM_OF_EDGES(E),
                          .DOT_PROD_WIDTH(DW)) bus_s ();

  gcn_coo_aggregator #(.NUM_OF_NODES(N), .NUM_OF_CLASSES(C), .NUM_OF_EDGES(E),
                       .DOT_PROD_WIDTH(DW), .AGG_WIDTH(20), .SELF_LOOP(1), .UNDIRECTED(1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  gcn_coo_aggregator #(.NUM_OF_NODES(N), .NUM_OF_CLASSES(C), .NUM_OF_EDGES(E),
                       .DOT_PROD_WIDTH(DW), .AGG_WIDTH(16), .SELF_LOOP(0), .UNDIRECTED(0))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  // Combinational memories
  always_comb begin
    bus_a.coo_in = '0;
    if (32'(bus_a.coo_address) < E) bus_a.coo_in = coo_a[bus_a.coo_address];
  end
  always_comb begin
    bus_a.fm_wm_row_in = '0;
    if (32'(bus_a.fm_wm_row_address) < N) bus_a.fm_wm_row_in = rows_a[bus_a.fm_wm_row_address];
  end
  always_comb begin
    bus_s.coo_in = '0;
    if (32'(bus_s.coo_address) < E) bus_s.coo_in = coo_s[bus_s.coo_address];
  end
  always_comb begin
    bus_s.fm_wm_row_in = '0;
    if (32'(bus_s.fm_wm_row_address) < N) bus_s.fm_wm_row_in = rows_s[bus_s.fm_wm_row_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned sadd(input longint unsigned a, input longint unsigned b,
                                           input longint unsigned lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

  // Reference: graph sums with saturation, invalid edges skipped and flagged
  function automatic exp_t model(input row_t r [N], input coo_t k [E], input bit self_loop,
                                 input bit undir, input int unsigned aggw);
    longint unsigned acc [N][C];
    longint unsigned lim;
    exp_t            x;
    int unsigned     s, d, b;
    lim = (64'(1) << aggw) - 64'(1);
    x   = '0;
    for (int n = 0; n < N; n++)
      for (int c = 0; c < C; c++) acc[n][c] = 0;
    if (self_loop)
      for (int n = 0; n < N; n++)
        for (int c = 0; c < C; c++) acc[n][c] = sadd(acc[n][c], 64'(r[n][c]), lim);
    for (int e = 0; e < E; e++) begin
      s = 32'(k[e][5:3]);
      d = 32'(k[e][2:0]);
      if (s >= N || d >= N) x.err = 1'b1;
      else begin
        for (int c = 0; c < C; c++) acc[s][c] = sadd(acc[s][c], 64'(r[d][c]), lim);
        if (undir)
          for (int c = 0; c < C; c++) acc[d][c] = sadd(acc[d][c], 64'(r[s][c]), lim);
      end
    end
    for (int n = 0; n < N; n++) begin
      b = 0;
      for (int c = 1; c < C; c++) if (acc[n][c] > acc[n][b]) b = c;
      x.ans[n] = 2'(b);
    end
    return x;
  endfunction

  // Start one run, bound the wait for done, and check against the scoreboard head
  task automatic run(input bit sel, input string tag, input int unsigned exp_lat,
                     input bit hold, input bit chk_clear);
    int unsigned cyc;
    exp_t        e;
    logic        dn;
    ans_t        held;
    @(negedge clk);
    if (sel) bus_s.start = 1'b1; else bus_a.start = 1'b1;
    @(posedge clk);
    cyc = 0;
    dn  = 1'b0;
    while (!dn && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      dn = sel ? bus_s.done : bus_a.done;
      if (chk_clear && cyc == 1) chk({tag, "_err_cleared"}, 64'(bus_a.coo_error), 64'(0));
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    e    = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    held = sel ? bus_s.max_addi_answer : bus_a.max_addi_answer;
    chk({tag, "_answers"}, 64'(held), 64'(e.ans));
    chk({tag, "_coo_error"}, 64'(sel ? bus_s.coo_error : bus_a.coo_error), 64'(e.err));
    if (hold) begin
      repeat (20) begin
        @(posedge clk); #1;
        chk({tag, "_hold_done"}, 64'(sel ? bus_s.done : bus_a.done), 64'(1));
      end
      chk({tag, "_hold_answers"}, 64'(bus_a.max_addi_answer), 64'(e.ans));
    end
    @(negedge clk);
    if (sel) bus_s.start = 1'b0; else bus_a.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, 64'(sel ? bus_s.done : bus_a.done), 64'(0));
  endtask

  task automatic load_basic();
    for (int n = 0; n < N; n++) rows_a[n] = '0;
    rows_a[2] = {16'd2, 16'd5, 16'd1};
    for (int e = 0; e < E; e++) coo_a[e] = {3'd0, 3'd2};
  endtask

  initial begin
    reset       = 1'b0;
    bus_a.start = 1'b0;
    bus_s.start = 1'b0;
    load_basic();
    for (int n = 0; n < N; n++) rows_s[n] = '0;
    for (int e = 0; e < E; e++) coo_s[e] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 64'(bus_a.done), 64'(0));
    chk("rst_coo_error", 64'(bus_a.coo_error), 64'(0));
    chk("rst_answers", 64'(bus_a.max_addi_answer), 64'(0));
    chk("rst_coo_addr", 64'(bus_a.coo_address), 64'(0));
    chk("rst_row_addr", 64'(bus_a.fm_wm_row_address), 64'(0));
    chk("rst_s_done", 64'(bus_s.done), 64'(0));

    @(negedge clk);
    reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_done", 64'(bus_a.done), 64'(0));
    end

    // Basic run, start held high after done
    load_basic();
    sb_q.push_back('{ans: 12'h011, err: 1'b0});
    run(1'b0, "basic", 25, 1'b1, 1'b0);

    // Tie-break: identical class scores everywhere
    for (int n = 0; n < N; n++) rows_a[n] = {16'd7, 16'd7, 16'd7};
    for (int e = 0; e < E; e++) coo_a[e] = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
    sb_q.push_back('{ans: 12'h000, err: 1'b0});
    run(1'b0, "tie", 25, 1'b0, 1'b0);

    // Random valid graphs against the reference model
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < N; n++)
        for (int c = 0; c < C; c++) rows_a[n][c] = 16'($urandom_range(0, 2000));
      for (int e = 0; e < E; e++) coo_a[e] = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
      sb_q.push_back(model(rows_a, coo_a, 1'b1, 1'b1, 20));
      run(1'b0, "random", 25, 1'b0, 1'b0);
    end

    // Invalid COO source; rerun shows the flag cleared at CLEAR then set again
    load_basic();
    coo_a[1] = {3'd7, 3'd2};
    sb_q.push_back('{ans: 12'h011, err: 1'b1});
    run(1'b0, "invalid", 25, 1'b0, 1'b0);
    sb_q.push_back(model(rows_a, coo_a, 1'b1, 1'b1, 20));
    run(1'b0, "invalid_rerun", 25, 1'b0, 1'b1);

    // Saturation on the 16-bit directed instance
    for (int n = 0; n < N; n++) rows_s[n] = {16'h0000, 16'h4000, 16'hC000};
    for (int e = 0; e < 3; e++) coo_s[e] = {3'd0, 3'd1};
    for (int e = 3; e < 6; e++) coo_s[e] = {3'd1, 3'd0};
    sb_q.push_back('{ans: 12'h000, err: 1'b0});
    run(1'b1, "saturate", 13, 1'b0, 1'b0);

    // Reset during EDGE_B of edge 3
    load_basic();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    repeat (13) @(posedge clk);
    #1;
    chk("mid_edge_a_row_addr", 64'(bus_a.fm_wm_row_address), 64'(2));
    @(posedge clk); #1;
    chk("mid_edge_b_coo_addr", 64'(bus_a.coo_address), 64'(3));
    reset       = 1'b0;
    bus_a.start = 1'b0;
    #1;
    chk("abort_done", 64'(bus_a.done), 64'(0));
    chk("abort_answers", 64'(bus_a.max_addi_answer), 64'(0));
    chk("abort_coo_addr", 64'(bus_a.coo_address), 64'(0));
    chk("abort_row_addr", 64'(bus_a.fm_wm_row_address), 64'(0));
    chk("abort_coo_error", 64'(bus_a.coo_error), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back('{ans: 12'h011, err: 1'b0});
    run(1'b0, "after_abort", 25, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
